// File: rtl/spi_wrapper_pkg.sv
// Shared definitions for the SPI slave wrapper and its RAM.
package spi_wrapper_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int RX_BITS = 10;
  localparam int TX_BITS = 8;

endpackage

// File: rtl/spi_ram.sv
// Command-decoding RAM behind the SPI slave: address latches, write port, read-out.
module spi_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid
);
  import spi_wrapper_pkg::*;

  logic [7:0]           mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      dout     <= '0;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      if (rx_valid) begin
        case (din[9:8])
          CMD_WR_ADDR: wr_addr <= ADDR_SIZE'(din[7:0]);
          CMD_RD_ADDR: rd_addr <= ADDR_SIZE'(din[7:0]);
          CMD_RD_DATA: begin
            dout     <= mem[rd_addr];
            tx_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Storage has no reset so contents survive rst_n; the write is still blocked while in reset.
  always_ff @(posedge clk) begin
    if (rst_n && rx_valid && (din[9:8] == CMD_WR_DATA))
      mem[wr_addr] <= din[7:0];
  end

endmodule

// File: rtl/spi_wrapper.sv
// SPI slave: command FSM, 10-bit MOSI shifter, 8-bit MISO shifter, RAM instance.
//   state     | meaning
//   IDLE      | SS_n high or frame just starting, MOSI ignored
//   CHK_CMD   | sample first MOSI bit to choose write/read path
//   WRITE     | shift 10 bits for a write-address or write-data command
//   READ_ADD  | shift 10 bits for a read-address command, then hold address
//   READ_DATA | shift 10 bits, then return one byte on MISO
module spi_wrapper
  import spi_wrapper_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);

  state_t     state, state_nxt;
  logic [3:0] bit_cnt;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [7:0] tx_shift;
  logic [3:0] tx_cnt;
  logic       rd_addr_held;

  logic abort, load_cnt, shift_en, frame_done, tx_load, tx_last;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!SS_n) state_nxt = CHK_CMD;
      CHK_CMD: begin
        if (SS_n)              state_nxt = IDLE;
        else if (!MOSI)        state_nxt = WRITE;
        else if (rd_addr_held) state_nxt = READ_DATA;
        else                   state_nxt = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: if (SS_n) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    abort      = (state != IDLE) && SS_n;
    load_cnt   = (state == CHK_CMD) && !SS_n;
    shift_en   = (state inside {WRITE, READ_ADD, READ_DATA}) && !SS_n && (bit_cnt != 4'd0);
    frame_done = shift_en && (bit_cnt == 4'd1);
    tx_load    = (state == READ_DATA) && !SS_n && tx_valid;
    tx_last    = (state == READ_DATA) && !SS_n && (tx_cnt == 4'd1);
  end

  // bit_cnt and tx_cnt count down remaining bits; 1 marks the final bit of each phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt      <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      tx_shift     <= '0;
      tx_cnt       <= '0;
      MISO         <= 1'b0;
      rd_addr_held <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (abort) begin
        bit_cnt  <= '0;
        rx_data  <= '0;
        tx_shift <= '0;
        tx_cnt   <= '0;
        MISO     <= 1'b0;
      end else begin
        if (load_cnt) begin
          bit_cnt <= 4'(RX_BITS);
        end else if (shift_en) begin
          rx_data  <= {rx_data[8:0], MOSI};
          bit_cnt  <= bit_cnt - 4'd1;
          rx_valid <= (bit_cnt == 4'd1);
        end
        if (tx_load) begin
          MISO     <= tx_data[7];
          tx_shift <= {tx_data[6:0], 1'b0};
          tx_cnt   <= 4'(TX_BITS - 1);
        end else if (tx_cnt != 4'd0) begin
          MISO     <= tx_shift[7];
          tx_shift <= {tx_shift[6:0], 1'b0};
          tx_cnt   <= tx_cnt - 4'd1;
        end else begin
          MISO <= 1'b0;
        end
      end
      // Held flag survives aborts; only reset, a finished read address or a finished read-out move it.
      if (frame_done && (state == READ_ADD)) rd_addr_held <= 1'b1;
      else if (tx_last)                      rd_addr_held <= 1'b0;
    end
  end

  spi_ram #(
    .MEM_DEPTH(MEM_DEPTH),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (rx_data),
    .rx_valid(rx_valid),
    .dout    (tx_data),
    .tx_valid(tx_valid)
  );

endmodule

// File: tb/tb_spi_wrapper.sv
// Scoreboard bench for spi_wrapper: directed frames plus randomized command mix.
module tb_spi_wrapper;

  logic clk = 1'b0;
  logic rst_n, SS_n, MOSI, MISO;
  int   cyc = 0;

  spi_wrapper #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .SS_n (SS_n),
    .MOSI (MOSI),
    .MISO (MISO)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         start;
    logic [7:0] val;
    int         nbits;
    bit         known;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 0;

  // Reference model: what the slave should remember, in plain terms.
  logic [7:0] m_mem [256];
  bit         m_known [256];
  logic [7:0] m_wr, m_rd;
  bit         m_held;

  localparam int P_WR = 0, P_RD_ADD = 1, P_RD_DATA = 2;

  logic [7:0] got;
  int         mon_idx;
  bit         ok;

  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() != 0 && cyc >= sb[0].start && cyc < sb[0].start + sb[0].nbits) begin
        mon_idx = cyc - sb[0].start;
        got[7 - mon_idx] = MISO;
        if (mon_idx == sb[0].nbits - 1) begin
          if (sb[0].known) begin
            n_cmp++;
            ok = 1;
            for (int k = 0; k < sb[0].nbits; k++)
              if (got[7 - k] !== sb[0].val[7 - k]) ok = 0;
            if (!ok) begin
              n_err++;
              $display("FAIL miso_byte at cycle %0d: got %h, required %h (first %0d bits)",
                       cyc, got, sb[0].val, sb[0].nbits);
            end
          end
          void'(sb.pop_front());
        end
      end else begin
        n_cmp++;
        if (MISO !== 1'b0) begin
          n_err++;
          $display("FAIL miso_idle at cycle %0d: got %b, required 0", cyc, MISO);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_wr   = 8'h00;
    m_rd   = 8'h00;
    m_held = 0;
  endtask

  task automatic do_reset();
    SS_n  = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    model_reset();
  endtask

  // Applies a completed 10-bit frame to the model; returns 1 when a MISO byte is due.
  task automatic model_apply(input int path, input logic [9:0] d, output bit tx);
    exp_t e;
    tx = 0;
    case (d[9:8])
      2'b00: m_wr = d[7:0];
      2'b01: begin m_mem[m_wr] = d[7:0]; m_known[m_wr] = 1; end
      2'b10: m_rd = d[7:0];
      default: begin
        if (path == P_RD_DATA) begin
          e.start = cyc + 2;
          e.val   = m_mem[m_rd];
          e.nbits = 8;
          e.known = m_known[m_rd];
          sb.push_back(e);
          m_held = 0;
          tx = 1;
        end
      end
    endcase
    if (path == P_RD_ADD) m_held = 1;
  endtask

  task automatic frame(input logic c, input logic [9:0] d, input int n);
    int path;
    bit tx;
    path = c ? (m_held ? P_RD_DATA : P_RD_ADD) : P_WR;
    SS_n = 1'b0;
    MOSI = 1'($urandom);
    tick();
    MOSI = c;
    tick();
    for (int i = 0; i < n; i++) begin
      MOSI = d[9 - i];
      tick();
    end
    if (n == 10) begin
      model_apply(path, d, tx);
      if (tx)
        for (int i = 0; i < 9; i++) begin
          MOSI = 1'($urandom);
          tick();
        end
    end
    SS_n = 1'b1;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t       e;
    int         r, n;
    logic [9:0] d;

    for (int i = 0; i < 256; i++) begin m_mem[i] = 8'h00; m_known[i] = 0; end
    model_reset();
    SS_n  = 1'b1;
    MOSI  = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    mon_en = 1;
    tick();

    // write FF at A5, read it back through READ_ADD then READ_DATA
    do_reset();
    frame(1'b0, {2'b00, 8'hA5}, 10);
    frame(1'b0, {2'b01, 8'hFF}, 10);
    frame(1'b1, {2'b10, 8'hA5}, 10);
    frame(1'b1, {2'b11, 8'(~$urandom)}, 10);

    // reset keeps memory; write 3C at 69 and read back
    do_reset();
    frame(1'b0, {2'b00, 8'h69}, 10);
    frame(1'b0, {2'b01, 8'h3C}, 10);
    frame(1'b1, {2'b10, 8'h69}, 10);
    frame(1'b1, {2'b11, 8'($urandom)}, 10);
    frame(1'b1, {2'b10, 8'hA5}, 10);
    frame(1'b1, {2'b11, 8'($urandom)}, 10);

    // aborted address frame leaves the previous write address in place
    frame(1'b0, {2'b00, 8'h10}, 10);
    frame(1'b0, {2'b00, 8'h20}, 5);
    frame(1'b0, {2'b01, 8'h77}, 10);
    frame(1'b1, {2'b10, 8'h10}, 10);
    frame(1'b1, {2'b11, 8'h00}, 10);

    // two writes to one address, last wins
    frame(1'b0, {2'b00, 8'h42}, 10);
    frame(1'b0, {2'b01, 8'h11}, 10);
    frame(1'b0, {2'b01, 8'h22}, 10);
    frame(1'b1, {2'b10, 8'h42}, 10);
    frame(1'b1, {2'b11, 8'h00}, 10);

    // reset in the middle of a MISO byte
    frame(1'b0, {2'b00, 8'h00}, 10);
    frame(1'b0, {2'b01, 8'h5A}, 10);
    frame(1'b1, {2'b10, 8'h69}, 10);
    SS_n = 1'b0;
    tick();
    MOSI = 1'b1;
    tick();
    d = {2'b11, 8'($urandom)};
    for (int i = 0; i < 10; i++) begin
      MOSI = d[9 - i];
      tick();
    end
    e.start = cyc + 2;
    e.val   = m_mem[m_rd];
    e.nbits = 3;
    e.known = m_known[m_rd];
    sb.push_back(e);
    repeat (4) tick();
    rst_n = 1'b0;
    SS_n  = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    model_reset();
    // after reset a 1-command must take the address path: this one yields no MISO
    frame(1'b1, {2'b11, 8'h00}, 10);
    frame(1'b1, {2'b11, 8'h00}, 10);

    // randomized command mix with occasional aborted frames
    for (int t = 0; t < 250; t++) begin
      r = $urandom_range(0, 9);
      n = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 9) : 10;
      if (r < 3)      frame(1'b0, {2'b00, 4'h0, 4'($urandom)}, n);
      else if (r < 6) frame(1'b0, {2'b01, 8'($urandom)}, n);
      else if (m_held) frame(1'b1, {2'b11, 8'($urandom)}, n);
      else             frame(1'b1, {2'b10, 4'h0, 4'($urandom)}, n);
    end

    for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
